// File: rtl/bcd_sched_pkg.sv
// rtl/bcd_sched_pkg.sv - shared definitions for the BCD conversion scheduler
//
// Purpose: FSM state encodings, default counter width and the per-digit
//          double-dabble correction used by bcd_conv_scheduler.
// Ports:   none (package).
package bcd_sched_pkg;

  // FSM state encodings
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CONV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  // Bit counter width for the default 8-bit input
  localparam int DEF_IN_W = 8;
  localparam int CNT_W    = $clog2(DEF_IN_W + 1);

  // Double-dabble correction for one digit. Applied to every digit of the
  // N_DIG-digit accumulator before each shift; only 5..9 are touched, so a
  // corrected digit never exceeds 12 and never carries into its neighbour.
  function automatic logic [3:0] digit_fix(input logic [3:0] d);
    return (d > 4'd4) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: grants one of N requesters, searching from ptr+1 (mod N) upward so
//          that the requester named by ptr gets the lowest priority.
// Ports:
//   req  in  N   request vector
//   ptr  in  PW  index of the previous winner (held by the parent)
//   en   in  1   grant enable; gnt is all-zero when low
//   gnt  out N   one-hot grant (zero when no request or not enabled)
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  logic found;

  // Outer loop walks priority order (distance k from ptr+1), inner loop
  // matches that position to a requester index; first hit wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        for (int i = 0; i < N; i++) begin
          if (!found && req[i] && (i == ((int'(ptr) + 1 + k) % N))) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// rtl/bcd_conv_scheduler.sv - shared sequential binary-to-BCD engine with round-robin requesters
//
// Purpose: one 1-bit-per-clock double-dabble converter shared by N_REQ
//          requesters; results land in per-requester BCD slots.
// Option:  define BCD_SIGNED_EN to treat req_data as two's complement
//          (magnitude converted, sign stored in sign_out). Ports are the same
//          in both builds; without it sign_out is tied to zero.
// Ports:
//   clk        in   1              rising-edge clock
//   rst        in   1              asynchronous active-high reset
//   req_valid  in   N_REQ          request pending per requester
//   req_data   in   N_REQ*IN_W     requester i data at [i*IN_W +: IN_W]
//   req_ready  out  N_REQ          one-hot accept, only in IDLE
//   bcd_out    out  N_REQ*4*N_DIG  result slot i at [i*4*N_DIG +: 4*N_DIG]
//   sign_out   out  N_REQ          sign flag per slot
//   done       out  N_REQ          one-cycle pulse when slot i was updated
//   busy       out  1              high in CONV and WRITE
module bcd_conv_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IN_W  = 8,
  parameter int N_DIG = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*IN_W-1:0]    req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ*4*N_DIG-1:0] bcd_out,
  output logic [N_REQ-1:0]         sign_out,
  output logic [N_REQ-1:0]         done,
  output logic                     busy
);

  localparam int CW = $clog2(IN_W + 1);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW = 4 * N_DIG;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [IN_W-1:0]  shreg;
  logic [IN_W-1:0]  shreg_nxt;
  logic [DW-1:0]    digits;
  logic [DW-1:0]    digits_adj;
  logic [DW-1:0]    digits_nxt;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] done_q;
  logic [IN_W-1:0]  sel_data;
  logic [IN_W-1:0]  load_val;
  logic             arb_en;
  logic [DW-1:0]    slot [N_REQ];

  assign arb_en = (state == IDLE);

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (gnt)
  );

  // Winner index and its data word
  always_comb begin
    gnt_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PW'(i);
        sel_data = req_data[i*IN_W +: IN_W];
      end
    end
  end

`ifdef BCD_SIGNED_EN
  logic             sign_cap;
  logic             sign_q;
  logic [N_REQ-1:0] sign_slot;

  // Negation in IN_W bits maps the most negative value onto 2**(IN_W-1),
  // which is exactly its magnitude when read as unsigned.
  assign sign_cap = sel_data[IN_W-1];
  assign load_val = sign_cap ? (~sel_data + 1'b1) : sel_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q    <= 1'b0;
      sign_slot <= '0;
    end else begin
      if (state == IDLE && (|gnt)) begin
        sign_q <= sign_cap;
      end
      if (state == CONV && cnt == CW'(1)) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (PW'(i) == owner) begin
            sign_slot[i] <= sign_q;
          end
        end
      end
    end
  end

  assign sign_out = sign_slot;
`else
  assign load_val = sel_data;
  assign sign_out = '0;
`endif

  always_comb begin
    digits_adj = digits;
    for (int d = 0; d < N_DIG; d++) begin
      digits_adj[4*d +: 4] = digit_fix(digits[4*d +: 4]);
    end
  end

  // {digits, shreg} shifted left by one after correction
  assign digits_nxt = {digits_adj[DW-2:0], shreg[IN_W-1]};
  assign shreg_nxt  = {shreg[IN_W-2:0], 1'b0};

  // The final shift writes straight into the owner's slot so the new value
  // and the done pulse are both visible during the WRITE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
      digits <= '0;
      owner  <= '0;
      ptr    <= PW'(N_REQ - 1);  // search begins at requester 0
      done_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        slot[i] <= '0;
      end
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (|gnt) begin
            shreg  <= load_val;
            digits <= '0;
            owner  <= gnt_idx;
            cnt    <= CW'(IN_W);
            state  <= CONV;
          end
        end
        CONV: begin
          shreg  <= shreg_nxt;
          digits <= digits_nxt;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            for (int i = 0; i < N_REQ; i++) begin
              if (PW'(i) == owner) begin
                slot[i]   <= digits_nxt;
                done_q[i] <= 1'b1;
              end
            end
            state <= WRITE;
          end
        end
        WRITE: begin
          ptr   <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    assign bcd_out[g*DW +: DW] = slot[g];
  end

  assign req_ready = gnt;
  assign done      = done_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// tb/tb_bcd_conv_scheduler.sv - directed and random bench for bcd_conv_scheduler
module tb_bcd_conv_scheduler;

  localparam int N_REQ = 3;
  localparam int IN_W  = 8;
  localparam int N_DIG = 3;
  localparam int DW    = 4 * N_DIG;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [N_REQ-1:0]         req_valid = '0;
  logic [N_REQ*IN_W-1:0]    req_data = '0;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*4*N_DIG-1:0] bcd_out;
  logic [N_REQ-1:0]         sign_out;
  logic [N_REQ-1:0]         done;
  logic                     busy;

  int total = 0;
  int bad   = 0;

  bcd_conv_scheduler #(.N_REQ(N_REQ), .IN_W(IN_W), .N_DIG(N_DIG)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .bcd_out   (bcd_out),
    .sign_out  (sign_out),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] slot_of(input int i);
    return bcd_out[i*DW +: DW];
  endfunction

  // Reference by division, independent of the shift-and-add method
  function automatic logic [DW-1:0] ref_bcd(input logic [IN_W-1:0] x);
    int m;
`ifdef BCD_SIGNED_EN
    m = x[IN_W-1] ? (256 - int'(x)) : int'(x);
`else
    m = int'(x);
`endif
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic ref_sign(input logic [IN_W-1:0] x);
`ifdef BCD_SIGNED_EN
    return x[IN_W-1];
`else
    return 1'b0 & x[0];
`endif
  endfunction

  // Single request from idx; returns accept vector, handshake-to-done latency,
  // done vector, slot contents and sign. Leaves the DUT back in IDLE.
  task automatic do_one(input int idx, input logic [IN_W-1:0] x,
                        output logic [N_REQ-1:0] rdy, output int lat,
                        output logic [N_REQ-1:0] dn, output logic [DW-1:0] got,
                        output logic sgn);
    req_data[idx*IN_W +: IN_W] = x;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    #1;
    rdy = req_ready;
    step();
    req_valid = '0;
    lat = -1;
    dn  = '0;
    for (int c = 1; c <= 20; c++) begin
      if (done != '0) begin
        lat = c;
        dn  = done;
        break;
      end
      step();
    end
    got = slot_of(idx);
    sgn = sign_out[idx];
    step();
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if (bcd_out !== '0) begin bad++; $display("FAIL reset_bcd got=%h exp=0", bcd_out); end
    total++; if (sign_out !== '0) begin bad++; $display("FAIL reset_sign got=%b exp=0", sign_out); end
    total++; if (done !== '0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_max();
    logic [N_REQ-1:0] rdy, dn;
    logic [DW-1:0] got;
    logic sgn;
    int lat;
    do_one(0, 8'd255, rdy, lat, dn, got, sgn);
    total++; if (rdy !== 3'b001) begin bad++; $display("FAIL max_ready got=%b exp=001", rdy); end
    total++; if (lat !== 9) begin bad++; $display("FAIL max_latency got=%0d exp=9", lat); end
    total++; if (dn !== 3'b001) begin bad++; $display("FAIL max_done got=%b exp=001", dn); end
`ifdef BCD_SIGNED_EN
    total++; if (got !== 12'h001 || sgn !== 1'b1) begin bad++; $display("FAIL max_bcd got=%h/%b exp=001/1", got, sgn); end
`else
    total++; if (got !== 12'h255 || sgn !== 1'b0) begin bad++; $display("FAIL max_bcd got=%h/%b exp=255/0", got, sgn); end
`endif
    total++; if (busy !== 1'b0 || done !== '0) begin bad++; $display("FAIL max_idle got=%b/%b exp=0/000", busy, done); end
  endtask

  task automatic test_boundaries();
    int            t_idx [5] = '{1, 0, 0, 0, 2};
    logic [7:0]    t_x   [5] = '{8'd99, 8'd0, 8'd9, 8'd100, 8'd127};
    logic [11:0]   t_exp [5] = '{12'h099, 12'h000, 12'h009, 12'h100, 12'h127};
    logic [N_REQ-1:0] rdy, dn, one;
    logic [DW-1:0] got;
    logic sgn;
    int lat;
    for (int k = 0; k < 5; k++) begin
      do_one(t_idx[k], t_x[k], rdy, lat, dn, got, sgn);
      one = '0;
      one[t_idx[k]] = 1'b1;
      total++; if (got !== t_exp[k]) begin bad++; $display("FAIL bound_bcd[%0d] got=%h exp=%h", k, got, t_exp[k]); end
      total++; if (rdy !== one || dn !== one) begin bad++; $display("FAIL bound_hs[%0d] got=%b/%b exp=%b", k, rdy, dn, one); end
    end
    total++; if (slot_of(1) !== 12'h099) begin bad++; $display("FAIL bound_hold got=%h exp=099", slot_of(1)); end
  endtask

  task automatic test_round_robin();
    int g_idx [4];
    int g_cyc [4];
    int n = 0;
    int exp_idx [4] = '{0, 1, 2, 0};
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    req_data  = {8'd30, 8'd20, 8'd10};
    req_valid = 3'b111;
    for (int c = 0; c < 60 && n < 4; c++) begin
      #1;
      if (req_ready != '0) begin
        total++; if ($countones(req_ready) != 1) begin bad++; $display("FAIL rr_onehot got=%b exp=onehot", req_ready); end
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g_idx[n] = i;
        g_cyc[n] = c;
        n++;
      end
      step();
    end
    req_valid = '0;
    total++; if (n !== 4) begin bad++; $display("FAIL rr_count got=%0d exp=4", n); end
    if (n == 4) begin
      for (int k = 0; k < 4; k++) begin
        total++; if (g_idx[k] !== exp_idx[k]) begin bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, g_idx[k], exp_idx[k]); end
      end
      total++; if (g_cyc[0] !== 0) begin bad++; $display("FAIL rr_first got=%0d exp=0", g_cyc[0]); end
      for (int k = 1; k < 4; k++) begin
        total++; if (g_cyc[k] - g_cyc[k-1] !== 10) begin bad++; $display("FAIL rr_gap[%0d] got=%0d exp=10", k, g_cyc[k] - g_cyc[k-1]); end
      end
    end
    for (int c = 0; c < 12; c++) step();
    total++; if (bcd_out !== {12'h030, 12'h020, 12'h010}) begin bad++; $display("FAIL rr_slots got=%h exp=030020010", bcd_out); end
  endtask

  task automatic test_reset_mid();
    int lat = -1;
    req_data[1*IN_W +: IN_W] = 8'd77;
    req_valid = 3'b010;
    #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL mid_grant got=%b exp=010", req_ready); end
    step();
    req_valid = '0;
    step();
    step();
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    total++; if (bcd_out !== '0 || done !== '0 || busy !== 1'b0 || sign_out !== '0 || req_ready !== '0)
      begin bad++; $display("FAIL mid_clear got=%h/%b/%b/%b/%b exp=all zero", bcd_out, done, busy, sign_out, req_ready); end
    step();
    total++; if (done !== '0) begin bad++; $display("FAIL mid_nodone got=%b exp=000", done); end
    step();
    rst = 1'b0;
    req_data  = {8'd33, 8'd22, 8'd11};
    req_valid = 3'b111;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL mid_first got=%b exp=001", req_ready); end
    step();
    req_valid = '0;
    for (int c = 1; c <= 20; c++) begin
      if (done != '0) begin lat = c; break; end
      step();
    end
    total++; if (lat !== 9 || done !== 3'b001) begin bad++; $display("FAIL mid_done got=%0d/%b exp=9/001", lat, done); end
    total++; if (slot_of(0) !== 12'h011 || slot_of(1) !== 12'h000)
      begin bad++; $display("FAIL mid_slots got=%h/%h exp=011/000", slot_of(0), slot_of(1)); end
    step();
  endtask

  task automatic test_sign();
    logic [N_REQ-1:0] rdy, dn;
    logic [DW-1:0] got;
    logic sgn;
    int lat;
    do_one(0, 8'h80, rdy, lat, dn, got, sgn);
`ifdef BCD_SIGNED_EN
    total++; if (got !== 12'h128 || sgn !== 1'b1) begin bad++; $display("FAIL sign_min got=%h/%b exp=128/1", got, sgn); end
    do_one(0, 8'hF6, rdy, lat, dn, got, sgn);
    total++; if (got !== 12'h010 || sgn !== 1'b1) begin bad++; $display("FAIL sign_neg10 got=%h/%b exp=010/1", got, sgn); end
    do_one(1, 8'd5, rdy, lat, dn, got, sgn);
    total++; if (got !== 12'h005 || sgn !== 1'b0) begin bad++; $display("FAIL sign_pos got=%h/%b exp=005/0", got, sgn); end
    total++; if (sign_out[0] !== 1'b1) begin bad++; $display("FAIL sign_hold got=%b exp=1", sign_out[0]); end
`else
    total++; if (got !== 12'h128 || sgn !== 1'b0) begin bad++; $display("FAIL usign_128 got=%h/%b exp=128/0", got, sgn); end
    do_one(0, 8'hF6, rdy, lat, dn, got, sgn);
    total++; if (got !== 12'h246 || sign_out !== '0) begin bad++; $display("FAIL usign_246 got=%h/%b exp=246/000", got, sign_out); end
`endif
  endtask

  task automatic test_random();
    logic [N_REQ-1:0] pend = '0;
    logic [IN_W-1:0]  pdata [N_REQ];
    logic [DW-1:0]    exp_slot [N_REQ];
    logic             exp_sgn [N_REQ];
    int               waits [N_REQ];
    int               ndone = 0;
    int               g;
    for (int i = 0; i < N_REQ; i++) begin
      pdata[i] = '0; exp_slot[i] = '0; exp_sgn[i] = 1'b0; waits[i] = 0;
    end
    for (int c = 0; c < 20000 && ndone < 1000; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]  = 1'b1;
          pdata[i] = 8'($urandom_range(0, 255));
        end
        req_valid[i] = pend[i];
        req_data[i*IN_W +: IN_W] = pdata[i];
      end
      #1;
      if (done != '0) begin
        total++; if ($countones(done) != 1) begin bad++; $display("FAIL rnd_done_onehot got=%b", done); end
        for (int i = 0; i < N_REQ; i++) begin
          if (done[i]) begin
            total++; if (slot_of(i) !== exp_slot[i] || sign_out[i] !== exp_sgn[i])
              begin bad++; $display("FAIL rnd_slot[%0d] got=%h/%b exp=%h/%b", i, slot_of(i), sign_out[i], exp_slot[i], exp_sgn[i]); end
          end
        end
        ndone++;
      end
      if (req_ready != '0) begin
        total++; if ($countones(req_ready) != 1 || (req_ready & ~pend) != '0)
          begin bad++; $display("FAIL rnd_grant got=%b pend=%b", req_ready, pend); end
        g = 0;
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
        for (int j = 0; j < N_REQ; j++) begin
          if (j != g && pend[j]) begin
            waits[j]++;
            total++; if (waits[j] > N_REQ - 1) begin bad++; $display("FAIL rnd_starve[%0d] got=%0d exp<=%0d", j, waits[j], N_REQ - 1); end
          end
        end
        exp_slot[g] = ref_bcd(pdata[g]);
        exp_sgn[g]  = ref_sign(pdata[g]);
        pend[g]     = 1'b0;
        waits[g]    = 0;
      end
      step();
    end
    req_valid = '0;
    total++; if (ndone < 1000) begin bad++; $display("FAIL rnd_count got=%0d exp=1000", ndone); end
    for (int c = 0; c < 12; c++) step();
  endtask

  initial begin
    test_reset();
    test_max();
    test_boundaries();
    test_round_robin();
    test_reset_mid();
    test_sign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
